// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage with data_ok handshake, response buffer, flush discard and sub-word loads
module mem_stage_lsu #(
    parameter int PC_W  = 32,
    parameter int DW    = 32,
    parameter int RF_AW = 5,
    localparam int OFF_W     = $clog2(DW / 8),
    localparam int ES_BUS_WD = PC_W + 2 + 3 + OFF_W + 1 + RF_AW + DW,
    localparam int WS_BUS_WD = PC_W + 1 + RF_AW + DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    output logic                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                 data_data_ok,
    input  logic [DW-1:0]        data_rdata,
    output logic                 ms_to_ds_rf_we,
    output logic [RF_AW-1:0]     ms_to_ds_rf_waddr,
    output logic [DW-1:0]        ms_to_ds_rf_wdata,
    output logic                 ms_to_ds_load_pending
);

    logic                 ms_valid;
    logic [ES_BUS_WD-1:0] bus_r;
    logic                 got_resp;
    logic                 buf_valid;
    logic                 discard;
    logic [DW-1:0]        rdata_buf;

    logic [PC_W-1:0]  pc;
    logic             mem_req;
    logic             mem_we;
    logic [2:0]       load_type;
    logic [OFF_W-1:0] byte_off;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [DW-1:0]    alu_result;

    assign {pc, mem_req, mem_we, load_type, byte_off, rf_we, rf_waddr, alu_result} = bus_r;

    logic acc;
    logic ms_ready_go;
    logic leave;

    // A response belongs to the held instruction only if it is still owed and not a stale one.
    assign acc            = data_data_ok && !discard && ms_valid && mem_req && !got_resp;
    assign ms_ready_go    = !mem_req || got_resp || acc;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign leave          = ms_to_ws_valid && ws_allowin;

    // Valid bit and instruction register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
        if (ms_allowin && es_to_ms_valid && !flush) begin
            bus_r <= es_to_ms_bus;
        end
    end

    // Response tracking and holding buffer for data that arrives while ws stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            got_resp  <= 1'b0;
            buf_valid <= 1'b0;
        end else if (flush || leave) begin
            got_resp  <= 1'b0;
            buf_valid <= 1'b0;
        end else if (acc) begin
            got_resp  <= 1'b1;
            buf_valid <= 1'b1;
        end
        if (acc && !leave) begin
            rdata_buf <= data_rdata;
        end
    end

    // A flushed load still owes one response; remember to drop it when it arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            discard <= 1'b0;
        end else if (flush && ms_valid && mem_req && !got_resp && !data_data_ok) begin
            discard <= 1'b1;
        end else if (data_data_ok && discard) begin
            discard <= 1'b0;
        end
    end

    logic [DW-1:0]    rd;
    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [DW-1:0]    byte_sh;
    logic [DW-1:0]    half_sh;
    logic [DW-1:0]    word_sh;
    logic [DW-1:0]    load_val;
    logic [DW-1:0]    rf_wdata;

    // Sub-word extraction: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        rd       = buf_valid ? rdata_buf : data_rdata;
        off_h    = byte_off & ~OFF_W'(1);
        off_w    = byte_off & ~OFF_W'(3);
        byte_sh  = rd >> {byte_off, 3'b000};
        half_sh  = rd >> {off_h, 3'b000};
        word_sh  = rd >> {off_w, 3'b000};
        load_val = rd;
        case (load_type)
            3'b001:  load_val = DW'($signed(byte_sh[7:0]));
            3'b010:  load_val = DW'(byte_sh[7:0]);
            3'b011:  load_val = DW'($signed(half_sh[15:0]));
            3'b100:  load_val = DW'(half_sh[15:0]);
            3'b101:  load_val = DW'(word_sh[31:0]);
            3'b110:  load_val = rd;
            default: load_val = DW'($signed(word_sh[31:0]));
        endcase
        rf_wdata = (mem_req && !mem_we) ? load_val : alu_result;
    end

    assign ms_to_ws_bus          = {pc, rf_we, rf_waddr, rf_wdata};
    assign ms_to_ds_rf_we        = ms_valid && rf_we;
    assign ms_to_ds_rf_waddr     = rf_waddr;
    assign ms_to_ds_rf_wdata     = rf_wdata;
    assign ms_to_ds_load_pending = ms_valid && mem_req && !mem_we && !got_resp && !acc;

endmodule
